// File: rtl/cic_interp_seq.sv
// Control sequencer for the time-multiplexed CIC interpolator: one slow load per input
// sample, then RATIO fast loads per channel, each result offered downstream via valid/ready.
module cic_interp_seq #(
  parameter int NCH     = 2,
  parameter int RATIO_W = 8,
  parameter int SETTLE  = 1,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RATIO_W-1:0] ratio,
  input  logic               shift_done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CH_W-1:0]    ch_sel,
  output logic [RATIO_W-1:0] phase,
  output logic               load_slow,
  output logic               pulse_slow,
  output logic               load_fast,
  output logic               pulse_fast,
  output logic               data_select,
  output logic               CIC_en,
  output logic               frame_done
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LD_SLOW = 3'd1;
  localparam logic [2:0] SET_S   = 3'd2;
  localparam logic [2:0] LD_FAST = 3'd3;
  localparam logic [2:0] SET_F   = 3'd4;
  localparam logic [2:0] SEND    = 3'd5;
  localparam logic [2:0] WAIT_SH = 3'd6;
  localparam int         NUM_ST  = 7;

  localparam logic [3:0]      SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
  localparam logic [CH_W-1:0] CH_LAST     = CH_W'(NCH - 1);
  // With no settling required the settle states are bypassed entirely.
  localparam logic [2:0]      AFTER_SLOW  = (SETTLE == 0) ? LD_FAST : SET_S;
  localparam logic [2:0]      AFTER_FAST  = (SETTLE == 0) ? SEND : SET_F;

  logic [2:0]         state_reg, state_next;
  logic [CH_W-1:0]    ch_reg, ch_next;
  logic [RATIO_W-1:0] phase_reg, phase_next;
  logic [RATIO_W-1:0] rl_reg, rl_next;
  logic [3:0]         settle_reg, settle_next;

  logic [NUM_ST-1:0]  in_state;
  logic [RATIO_W-1:0] phase_last;
  logic               last_ch;
  logic               last_phase;
  logic               accept;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ST; gi++) begin : g_state_decode
      assign in_state[gi] = (state_reg == 3'(gi));
    end
  endgenerate

  assign phase_last = rl_reg - 1'b1;
  assign last_ch    = (ch_reg == CH_LAST);
  assign last_phase = (phase_reg == phase_last);
  assign accept     = in_state[SEND] & out_ready;

  always_comb begin
    state_next  = state_reg;
    ch_next     = ch_reg;
    phase_next  = phase_reg;
    rl_next     = rl_reg;
    settle_next = settle_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          state_next = LD_SLOW;
          rl_next    = (ratio == '0) ? RATIO_W'(1) : ratio;
          ch_next    = '0;
          phase_next = '0;
        end
      end
      LD_SLOW: begin
        settle_next = '0;
        state_next  = AFTER_SLOW;
      end
      SET_S: begin
        if (settle_reg == SETTLE_LAST) begin
          settle_next = '0;
          state_next  = LD_FAST;
        end else begin
          settle_next = settle_reg + 1'b1;
        end
      end
      LD_FAST: begin
        settle_next = '0;
        state_next  = AFTER_FAST;
      end
      SET_F: begin
        if (settle_reg == SETTLE_LAST) begin
          settle_next = '0;
          state_next  = SEND;
        end else begin
          settle_next = settle_reg + 1'b1;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (!last_ch) begin
            ch_next    = ch_reg + 1'b1;
            state_next = LD_FAST;
          end else if (!last_phase) begin
            ch_next    = '0;
            phase_next = phase_reg + 1'b1;
            state_next = WAIT_SH;
          end else begin
            ch_next    = '0;
            phase_next = '0;
            state_next = IDLE;
          end
        end
      end
      WAIT_SH: begin
        if (shift_done) begin
          state_next = LD_FAST;
        end
      end
      default: begin
        state_next  = IDLE;
        ch_next     = '0;
        phase_next  = '0;
        settle_next = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_reg  <= IDLE;
      ch_reg     <= '0;
      phase_reg  <= '0;
      rl_reg     <= '0;
      settle_reg <= '0;
    end else begin
      state_reg  <= state_next;
      ch_reg     <= ch_next;
      phase_reg  <= phase_next;
      rl_reg     <= rl_next;
      settle_reg <= settle_next;
    end
  end

  assign in_ready    = in_state[IDLE];
  assign out_valid   = in_state[SEND];
  assign load_slow   = in_state[LD_SLOW];
  assign pulse_slow  = in_state[LD_SLOW];
  assign load_fast   = in_state[LD_FAST];
  assign pulse_fast  = in_state[LD_FAST];
  assign data_select = in_state[LD_FAST] & (phase_reg == '0);
  assign ch_sel      = ch_reg;
  assign phase       = phase_reg;
  // Filter is frozen only while a result is stalled by downstream back-pressure.
  assign CIC_en      = ~(in_state[SEND] & ~out_ready);
  assign frame_done  = accept & last_ch & last_phase & ~RESET;

endmodule

// File: tb/tb_cic_interp_seq.sv
// Scoreboard bench for cic_interp_seq: expected sends queued at each input handshake,
// a monitor pops and compares on every accepted output.
module tb_cic_interp_seq;

  localparam int NCH = 2;

  typedef struct {
    int ch;
    int ph;
    int fd;
  } exp_t;

  logic       CLOCK;
  logic       RESET;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] ratio;
  logic       shift_done;
  logic       out_valid;
  logic       out_ready;
  logic [0:0] ch_sel;
  logic [7:0] phase;
  logic       load_slow, pulse_slow, load_fast, pulse_fast;
  logic       data_select, CIC_en, frame_done;

  logic       iv0, ir0, ov0, ls0, ps0, lf0, pf0, ds0, en0, fd0;
  logic [0:0] cs0;
  logic [7:0] ph0;
  logic       iv3, ir3, ov3, ls3, ps3, lf3, pf3, ds3, en3, fd3;
  logic [0:0] cs3;
  logic [7:0] ph3;
  logic [7:0] lat_ratio;
  logic       lat_shift;
  logic       lat_ready;

  exp_t sb[$];
  int n_checks, n_fail;
  int n_ls, n_lf, n_ds, n_ds_bad, n_sh, n_frames;

  cic_interp_seq #(.NCH(NCH), .RATIO_W(8), .SETTLE(1)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
    .ratio(ratio), .shift_done(shift_done), .out_valid(out_valid), .out_ready(out_ready),
    .ch_sel(ch_sel), .phase(phase), .load_slow(load_slow), .pulse_slow(pulse_slow),
    .load_fast(load_fast), .pulse_fast(pulse_fast), .data_select(data_select),
    .CIC_en(CIC_en), .frame_done(frame_done)
  );

  cic_interp_seq #(.NCH(NCH), .RATIO_W(8), .SETTLE(0)) dut_s0 (
    .CLOCK(CLOCK), .RESET(RESET), .in_valid(iv0), .in_ready(ir0),
    .ratio(lat_ratio), .shift_done(lat_shift), .out_valid(ov0), .out_ready(lat_ready),
    .ch_sel(cs0), .phase(ph0), .load_slow(ls0), .pulse_slow(ps0),
    .load_fast(lf0), .pulse_fast(pf0), .data_select(ds0),
    .CIC_en(en0), .frame_done(fd0)
  );

  cic_interp_seq #(.NCH(NCH), .RATIO_W(8), .SETTLE(3)) dut_s3 (
    .CLOCK(CLOCK), .RESET(RESET), .in_valid(iv3), .in_ready(ir3),
    .ratio(lat_ratio), .shift_done(lat_shift), .out_valid(ov3), .out_ready(lat_ready),
    .ch_sel(cs3), .phase(ph3), .load_slow(ls3), .pulse_slow(ps3),
    .load_fast(lf3), .pulse_fast(pf3), .data_select(ds3),
    .CIC_en(en3), .frame_done(fd3)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Inputs change and outputs are read 2 time units after each rising edge.
  task automatic step();
    @(posedge CLOCK);
    #2;
  endtask

  task automatic push_frame(input int r);
    for (int p = 0; p < r; p++) begin
      for (int c = 0; c < NCH; c++) begin
        sb.push_back('{ch: c, ph: p, fd: ((p == r - 1) && (c == NCH - 1)) ? 1 : 0});
      end
    end
  endtask

  task automatic send_sample(input int r, input int eff, input bit hold);
    int t;
    in_valid = 1'b1;
    ratio    = 8'(r);
    t = 0;
    while (!in_ready && t < 200) begin
      step();
      t++;
    end
    chk("handshake_in_ready", int'(in_ready), 1);
    $display("sample: ratio=%0d effective_R=%0d hold_valid=%0d", r, eff, hold);
    push_frame(eff);
    step();
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_frame();
    int start, t;
    start = n_frames;
    t = 0;
    while (n_frames == start && t < 500) begin
      step();
      t++;
    end
    chk("frame_completed", n_frames - start, 1);
  endtask

  task automatic wait_out_valid();
    int t;
    t = 0;
    while (!out_valid && t < 100) begin
      step();
      t++;
    end
    chk("out_valid_reached", int'(out_valid), 1);
  endtask

  initial begin
    int ls_s, lf_s, ds_s, dsb_s, sh_s, fr_s, n;
    CLOCK = 1'b0; RESET = 1'b1; in_valid = 1'b0; ratio = 8'd0;
    shift_done = 1'b0; out_ready = 1'b1;
    iv0 = 1'b0; iv3 = 1'b0; lat_ratio = 8'd1; lat_shift = 1'b0; lat_ready = 1'b1;
    n_checks = 0; n_fail = 0;
    n_ls = 0; n_lf = 0; n_ds = 0; n_ds_bad = 0; n_sh = 0; n_frames = 0;

    fork
      // Output monitor / scoreboard
      forever begin
        exp_t e;
        @(negedge CLOCK);
        if (load_slow) n_ls++;
        if (load_fast) n_lf++;
        if (data_select) begin
          n_ds++;
          if (phase != 8'd0 || !load_fast) n_ds_bad++;
        end
        if (out_valid && out_ready && !RESET) begin
          chk("send_expected", (sb.size() > 0) ? 1 : 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            $display("send: ch=%0d phase=%0d frame_done=%0d (exp %0d/%0d/%0d)",
                     ch_sel, phase, frame_done, e.ch, e.ph, e.fd);
            chk("send_ch", int'(ch_sel), e.ch);
            chk("send_phase", int'(phase), e.ph);
            chk("send_frame_done", int'(frame_done), e.fd);
          end
        end else if (frame_done) begin
          chk("frame_done_without_accept", int'(frame_done), 0);
        end
        if (frame_done) n_frames++;
      end
      // Output shifter model: shift_done after 3 cycles in WAIT_SH
      forever begin
        @(posedge CLOCK);
        #3;
        if (out_valid && out_ready && ch_sel == 1'(NCH - 1) && !frame_done && !RESET) begin
          for (int i = 0; i < 3; i++) begin
            @(posedge CLOCK);
            #3;
            chk("wait_sh_no_valid", int'(out_valid), 0);
          end
          shift_done = 1'b1;
          n_sh++;
          @(posedge CLOCK);
          #3;
          shift_done = 1'b0;
          chk("load_fast_after_shift", int'(load_fast), 1);
        end
      end
    join_none

    repeat (3) step();
    RESET = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_CIC_en", int'(CIC_en), 1);
    chk("rst_load_slow", int'(load_slow), 0);
    chk("rst_ch_sel", int'(ch_sel), 0);
    chk("rst_phase", int'(phase), 0);
    chk("rst_frame_done", int'(frame_done), 0);

    // Full frame, R=4
    ls_s = n_ls; lf_s = n_lf; ds_s = n_ds; dsb_s = n_ds_bad; sh_s = n_sh;
    send_sample(4, 4, 1'b0);
    wait_frame();
    chk("r4_load_slow", n_ls - ls_s, 1);
    chk("r4_load_fast", n_lf - lf_s, 8);
    chk("r4_data_select", n_ds - ds_s, 2);
    chk("r4_data_select_bad", n_ds_bad - dsb_s, 0);
    chk("r4_shift_waits", n_sh - sh_s, 3);

    // ratio=0 behaves as R=1
    ls_s = n_ls; lf_s = n_lf; ds_s = n_ds; sh_s = n_sh;
    send_sample(0, 1, 1'b0);
    wait_frame();
    chk("r0_load_slow", n_ls - ls_s, 1);
    chk("r0_load_fast", n_lf - lf_s, 2);
    chk("r0_data_select", n_ds - ds_s, 2);
    chk("r0_shift_waits", n_sh - sh_s, 0);
    chk("r0_back_idle", int'(in_ready), 1);

    // Back-pressure: 6 stalled cycles in SEND
    out_ready = 1'b0;
    send_sample(1, 1, 1'b0);
    wait_out_valid();
    for (int i = 0; i < 6; i++) begin
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_CIC_en", int'(CIC_en), 0);
      chk("stall_ch", int'(ch_sel), 0);
      chk("stall_phase", int'(phase), 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("stall_release_CIC_en", int'(CIC_en), 1);
    wait_frame();

    // Ratio changed mid-frame with in_valid held high
    send_sample(4, 4, 1'b1);
    ratio = 8'd2;
    wait_frame();
    lf_s = n_lf;
    send_sample(2, 2, 1'b0);
    wait_frame();
    chk("r2_load_fast", n_lf - lf_s, 4);

    // Reset while a result is pending in SEND
    fr_s = n_frames;
    out_ready = 1'b0;
    send_sample(1, 1, 1'b0);
    wait_out_valid();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    sb.delete();
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_CIC_en", int'(CIC_en), 1);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_ch_sel", int'(ch_sel), 0);
    chk("midrst_no_frame_done", n_frames - fr_s, 0);
    step();
    chk("midrst_next_in_ready", int'(in_ready), 1);
    chk("midrst_next_out_valid", int'(out_valid), 0);
    out_ready = 1'b1;
    send_sample(3, 3, 1'b0);
    wait_frame();

    // First-output latency for SETTLE=0 and SETTLE=3
    chk("lat0_in_ready", int'(ir0), 1);
    iv0 = 1'b1;
    n = 0;
    do begin
      step();
      iv0 = 1'b0;
      n++;
    end while (!ov0 && n < 50);
    $display("latency: SETTLE=0 first out_valid after %0d cycles", n);
    chk("latency_settle0", n, 3);

    chk("lat3_in_ready", int'(ir3), 1);
    iv3 = 1'b1;
    n = 0;
    do begin
      step();
      iv3 = 1'b0;
      n++;
    end while (!ov3 && n < 50);
    $display("latency: SETTLE=3 first out_valid after %0d cycles", n);
    chk("latency_settle3", n, 9);

    repeat (5) step();
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
